// File: rtl/fu_logic_rs.sv
// Reservation station for the logic FU: compacting age-ordered queue with CDB wakeup.
// A ready op issues two cycles after dispatch; dispatch stalls only when all entries are valid.
module fu_logic_rs #(
  parameter int RS_ENTRY     = 4,
  parameter int WORD_SIZE_P  = 16,
  parameter int WIDTH_OP     = 4,
  parameter int NUM_PHYS_REG = 32,
  parameter int ROB_ENTRY    = 16,
  localparam int TW = $clog2(NUM_PHYS_REG),
  localparam int RW = $clog2(ROB_ENTRY)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   disp_v_i,
  output logic                   disp_ready_o,
  input  logic [WIDTH_OP-1:0]    disp_opcode_i,
  input  logic                   disp_src1_rdy_i,
  input  logic                   disp_src2_rdy_i,
  input  logic [TW-1:0]          disp_src1_tag_i,
  input  logic [TW-1:0]          disp_src2_tag_i,
  input  logic [WORD_SIZE_P-1:0] disp_src1_val_i,
  input  logic [WORD_SIZE_P-1:0] disp_src2_val_i,
  input  logic [RW-1:0]          disp_rob_dest_i,
  input  logic [TW-1:0]          disp_reg_dest_i,
  input  logic                   cdb_v_i,
  input  logic [TW-1:0]          cdb_tag_i,
  input  logic [WORD_SIZE_P-1:0] cdb_result_i,
  output logic                   exe_v_o,
  output logic [WIDTH_OP-1:0]    opcode_o,
  output logic [WORD_SIZE_P-1:0] operand1_o,
  output logic [WORD_SIZE_P-1:0] operand2_o,
  output logic [RW-1:0]          rob_dest_o,
  output logic [TW-1:0]          reg_dest_o
);
  localparam int IW = (RS_ENTRY > 1) ? $clog2(RS_ENTRY) : 1;
  localparam int CW = $clog2(RS_ENTRY + 1);

  logic                   r_vld  [RS_ENTRY];
  logic [WIDTH_OP-1:0]    r_op   [RS_ENTRY];
  logic                   r_rdy1 [RS_ENTRY];
  logic                   r_rdy2 [RS_ENTRY];
  logic [TW-1:0]          r_tag1 [RS_ENTRY];
  logic [TW-1:0]          r_tag2 [RS_ENTRY];
  logic [WORD_SIZE_P-1:0] r_val1 [RS_ENTRY];
  logic [WORD_SIZE_P-1:0] r_val2 [RS_ENTRY];
  logic [RW-1:0]          r_rob  [RS_ENTRY];
  logic [TW-1:0]          r_reg  [RS_ENTRY];
  logic [CW-1:0]          r_count;

  logic                   r_exe_v;
  logic [WIDTH_OP-1:0]    r_opcode;
  logic [WORD_SIZE_P-1:0] r_operand1;
  logic [WORD_SIZE_P-1:0] r_operand2;
  logic [RW-1:0]          r_rob_dest;
  logic [TW-1:0]          r_reg_dest;

  logic                   w_wk_rdy1 [RS_ENTRY];
  logic                   w_wk_rdy2 [RS_ENTRY];
  logic [WORD_SIZE_P-1:0] w_wk_val1 [RS_ENTRY];
  logic [WORD_SIZE_P-1:0] w_wk_val2 [RS_ENTRY];

  logic                   w_n_vld  [RS_ENTRY];
  logic [WIDTH_OP-1:0]    w_n_op   [RS_ENTRY];
  logic                   w_n_rdy1 [RS_ENTRY];
  logic                   w_n_rdy2 [RS_ENTRY];
  logic [TW-1:0]          w_n_tag1 [RS_ENTRY];
  logic [TW-1:0]          w_n_tag2 [RS_ENTRY];
  logic [WORD_SIZE_P-1:0] w_n_val1 [RS_ENTRY];
  logic [WORD_SIZE_P-1:0] w_n_val2 [RS_ENTRY];
  logic [RW-1:0]          w_n_rob  [RS_ENTRY];
  logic [TW-1:0]          w_n_reg  [RS_ENTRY];

  logic          w_sel_vld;
  logic [IW-1:0] w_sel_idx;
  logic          w_take;
  logic [CW-1:0] w_wr_idx;
  logic          w_d_hit1;
  logic          w_d_hit2;

  assign disp_ready_o = (r_count != CW'(RS_ENTRY));
  assign w_take       = disp_v_i & disp_ready_o;
  assign w_wr_idx     = r_count - CW'(w_sel_vld);
  assign w_d_hit1     = cdb_v_i & ~disp_src1_rdy_i & (disp_src1_tag_i == cdb_tag_i);
  assign w_d_hit2     = cdb_v_i & ~disp_src2_rdy_i & (disp_src2_tag_i == cdb_tag_i);

  // Scan downward so the lowest (oldest) ready index wins.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    for (int i = RS_ENTRY - 1; i >= 0; i--) begin
      if (r_vld[i] && r_rdy1[i] && r_rdy2[i]) begin
        w_sel_vld = 1'b1;
        w_sel_idx = IW'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RS_ENTRY; i++) begin
      w_wk_rdy1[i] = r_rdy1[i];
      w_wk_rdy2[i] = r_rdy2[i];
      w_wk_val1[i] = r_val1[i];
      w_wk_val2[i] = r_val2[i];
      if (cdb_v_i && r_vld[i] && !r_rdy1[i] && (r_tag1[i] == cdb_tag_i)) begin
        w_wk_rdy1[i] = 1'b1;
        w_wk_val1[i] = cdb_result_i;
      end
      if (cdb_v_i && r_vld[i] && !r_rdy2[i] && (r_tag2[i] == cdb_tag_i)) begin
        w_wk_rdy2[i] = 1'b1;
        w_wk_val2[i] = cdb_result_i;
      end
    end
  end

  // Compaction over the issued slot, then the new op lands just past the survivors.
  always_comb begin
    for (int i = 0; i < RS_ENTRY; i++) begin
      if (w_sel_vld && (IW'(i) >= w_sel_idx)) begin
        w_n_vld[i]  = (i < RS_ENTRY - 1) ? r_vld[(i < RS_ENTRY - 1) ? i + 1 : i] : 1'b0;
        w_n_op[i]   = r_op[(i < RS_ENTRY - 1) ? i + 1 : i];
        w_n_rdy1[i] = w_wk_rdy1[(i < RS_ENTRY - 1) ? i + 1 : i];
        w_n_rdy2[i] = w_wk_rdy2[(i < RS_ENTRY - 1) ? i + 1 : i];
        w_n_tag1[i] = r_tag1[(i < RS_ENTRY - 1) ? i + 1 : i];
        w_n_tag2[i] = r_tag2[(i < RS_ENTRY - 1) ? i + 1 : i];
        w_n_val1[i] = w_wk_val1[(i < RS_ENTRY - 1) ? i + 1 : i];
        w_n_val2[i] = w_wk_val2[(i < RS_ENTRY - 1) ? i + 1 : i];
        w_n_rob[i]  = r_rob[(i < RS_ENTRY - 1) ? i + 1 : i];
        w_n_reg[i]  = r_reg[(i < RS_ENTRY - 1) ? i + 1 : i];
      end else begin
        w_n_vld[i]  = r_vld[i];
        w_n_op[i]   = r_op[i];
        w_n_rdy1[i] = w_wk_rdy1[i];
        w_n_rdy2[i] = w_wk_rdy2[i];
        w_n_tag1[i] = r_tag1[i];
        w_n_tag2[i] = r_tag2[i];
        w_n_val1[i] = w_wk_val1[i];
        w_n_val2[i] = w_wk_val2[i];
        w_n_rob[i]  = r_rob[i];
        w_n_reg[i]  = r_reg[i];
      end
      if (w_take && (CW'(i) == w_wr_idx)) begin
        w_n_vld[i]  = 1'b1;
        w_n_op[i]   = disp_opcode_i;
        w_n_rdy1[i] = disp_src1_rdy_i | w_d_hit1;
        w_n_rdy2[i] = disp_src2_rdy_i | w_d_hit2;
        w_n_tag1[i] = disp_src1_tag_i;
        w_n_tag2[i] = disp_src2_tag_i;
        w_n_val1[i] = w_d_hit1 ? cdb_result_i : disp_src1_val_i;
        w_n_val2[i] = w_d_hit2 ? cdb_result_i : disp_src2_val_i;
        w_n_rob[i]  = disp_rob_dest_i;
        w_n_reg[i]  = disp_reg_dest_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < RS_ENTRY; i++) begin
        r_vld[i]  <= 1'b0;
        r_op[i]   <= '0;
        r_rdy1[i] <= 1'b0;
        r_rdy2[i] <= 1'b0;
        r_tag1[i] <= '0;
        r_tag2[i] <= '0;
        r_val1[i] <= '0;
        r_val2[i] <= '0;
        r_rob[i]  <= '0;
        r_reg[i]  <= '0;
      end
      r_count    <= '0;
      r_exe_v    <= 1'b0;
      r_opcode   <= '0;
      r_operand1 <= '0;
      r_operand2 <= '0;
      r_rob_dest <= '0;
      r_reg_dest <= '0;
    end else begin
      for (int i = 0; i < RS_ENTRY; i++) begin
        r_vld[i]  <= flush_i ? 1'b0 : w_n_vld[i];
        r_op[i]   <= w_n_op[i];
        r_rdy1[i] <= w_n_rdy1[i];
        r_rdy2[i] <= w_n_rdy2[i];
        r_tag1[i] <= w_n_tag1[i];
        r_tag2[i] <= w_n_tag2[i];
        r_val1[i] <= w_n_val1[i];
        r_val2[i] <= w_n_val2[i];
        r_rob[i]  <= w_n_rob[i];
        r_reg[i]  <= w_n_reg[i];
      end
      if (flush_i) begin
        r_count <= '0;
        r_exe_v <= 1'b0;
      end else begin
        r_count <= r_count + CW'(w_take) - CW'(w_sel_vld);
        r_exe_v <= w_sel_vld;
        if (w_sel_vld) begin
          r_opcode   <= r_op[w_sel_idx];
          r_operand1 <= r_val1[w_sel_idx];
          r_operand2 <= r_val2[w_sel_idx];
          r_rob_dest <= r_rob[w_sel_idx];
          r_reg_dest <= r_reg[w_sel_idx];
        end
      end
    end
  end

  assign exe_v_o    = r_exe_v;
  assign opcode_o   = r_opcode;
  assign operand1_o = r_operand1;
  assign operand2_o = r_operand2;
  assign rob_dest_o = r_rob_dest;
  assign reg_dest_o = r_reg_dest;

endmodule
